// File: rtl/wb_queue_pkg.sv
// Shared types and constants for the writeback queue and its forwarding lookup.
// No logic, so no latency.
// No flow control lives here.
package wb_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // One deferred writeback: destination register and its value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_fwd_lookup.sv
// Youngest-match search of the queued entries for one read address.
// Combinational, zero latency.
// No flow control; the result is valid whenever the inputs are.
module wb_queue_fwd_lookup
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  wb_entry_t               i_entries [DEPTH],
  input  logic [PTR_W-1:0]        i_head,
  input  logic [CNT_W-1:0]        i_count,
  input  logic [REG_ADDR_W-1:0]   i_rr,
  output logic                    o_hit,
  output logic [REG_DATA_W-1:0]   o_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PTR_W'(i);
      if ((CNT_W'(i) < i_count) && (i_rr != REG_ZERO) &&
          (i_entries[w_idx].addr == i_rr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Register-bank write port arbiter: pipeline writeback first, deferred FIFO drains when idle.
// Write/WA/WD are combinational; a queued entry reaches the bank the cycle after acceptance at the earliest.
// in_ready comes from registered count only; a pipe_write cycle stalls the drain.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_write,
  input  logic [ADDR_W-1:0]           pipe_wa,
  input  logic [DATA_W-1:0]           pipe_wd,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           in_wa,
  input  logic [DATA_W-1:0]           in_wd,
  input  logic [ADDR_W-1:0]           rr1,
  input  logic [ADDR_W-1:0]           rr2,
  output logic                        fwd1_hit,
  output logic [DATA_W-1:0]           fwd1_data,
  output logic                        fwd2_hit,
  output logic [DATA_W-1:0]           fwd2_data,
  output logic                        Write,
  output logic [ADDR_W-1:0]           WA,
  output logic [DATA_W-1:0]           WD,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_accept;
  logic w_enq;
  logic w_deq;

  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign count    = r_count;
  assign w_accept = in_valid && in_ready;
  // Writes to register 0 are acknowledged but dropped: the bank would discard them anyway.
  assign w_enq    = w_accept && (in_wa != REG_ZERO);
  assign w_deq    = !pipe_write && (r_count != '0);

  // Port arbitration; gating with rst_n keeps Write low for the whole reset window.
  always_comb begin
    Write = 1'b0;
    WA    = '0;
    WD    = '0;
    if (rst_n) begin
      if (pipe_write) begin
        Write = 1'b1;
        WA    = pipe_wa;
        WD    = pipe_wd;
      end else if (r_count != '0) begin
        Write = 1'b1;
        WA    = r_mem[r_head].addr;
        WD    = r_mem[r_head].data;
      end
    end
  end

  // Entry storage; contents are meaningless outside [head, head+count) so no reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= '{addr: in_wa, data: in_wd};
    end
  end

  // Pointers and occupancy; count alone tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  wb_queue_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
    .i_entries (r_mem),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_rr      (rr1),
    .o_hit     (fwd1_hit),
    .o_data    (fwd1_data)
  );

  wb_queue_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
    .i_entries (r_mem),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_rr      (rr2),
    .o_hit     (fwd2_hit),
    .o_data    (fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus a randomized run against a queue-based model.
// Inputs change 1ns after posedge; outputs are checked on the negedge.
// The bench itself plays the register bank.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_write;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wa;
  logic [31:0] in_wd;
  logic [4:0]  rr1, rr2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        Write;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] bank [32];

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_write(pipe_write), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .in_valid(in_valid), .in_ready(in_ready), .in_wa(in_wa), .in_wd(in_wd),
    .rr1(rr1), .rr2(rr2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .Write(Write), .WA(WA), .WD(WD), .count(count)
  );

  always #5 clk = ~clk;

  // Bench-side register bank, written on the clock edge like the real one.
  always @(posedge clk) begin
    if (rst_n && Write) bank[WA] <= WD;
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_write = 0; pipe_wa = 0; pipe_wd = 0;
    in_valid = 0; in_wa = 0; in_wd = 0;
    rr1 = 0; rr2 = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) bank[i] = 32'h0;
    idle_inputs();
    rst_n = 0;
    pipe_write = 1; pipe_wa = 5'd9; pipe_wd = 32'h1234;
    rr1 = 5'd3;
    #2;
    n_cmp++; if (Write !== 1'b0) begin n_err++; $display("FAIL reset_write got=%0b exp=0", Write); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    n_cmp++; if (WA !== 5'd0 || WD !== 32'd0) begin n_err++; $display("FAIL reset_wa_wd got=%0d/%h exp=0/0", WA, WD); end
    advance();
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (Write !== 1'b0) begin n_err++; $display("FAIL idle_write got=%0b exp=0", Write); end
    n_cmp++; if (in_ready !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL idle_ready_count got=%0b/%0d exp=1/0", in_ready, count); end
    n_cmp++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin n_err++; $display("FAIL idle_fwd1 got=%0b/%h exp=0/0", fwd1_hit, fwd1_data); end
    advance();
  endtask

  task automatic test_single();
    in_valid = 1; in_wa = 5'd3; in_wd = 32'hAAAA0001;
    @(negedge clk);
    n_cmp++; if (Write !== 1'b0) begin n_err++; $display("FAIL single_nowrite_same_cycle got=%0b exp=0", Write); end
    advance();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (Write !== 1'b1 || WA !== 5'd3 || WD !== 32'hAAAA0001)
      begin n_err++; $display("FAIL single_drain got=%0b/%0d/%h exp=1/3/aaaa0001", Write, WA, WD); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1 got=%0d exp=1", count); end
    advance();
    @(negedge clk);
    n_cmp++; if (Write !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL single_empty got=%0b/%0d exp=0/0", Write, count); end
    advance();
  endtask

  task automatic test_fill_full();
    logic [31:0] fd [5];
    logic [31:0] pd;
    for (int i = 0; i < 5; i++) fd[i] = $urandom;
    for (int c = 0; c < 6; c++) begin
      pd = $urandom;
      pipe_write = 1; pipe_wa = 5'(10 + c); pipe_wd = pd;
      in_valid = (c < 5); in_wa = 5'(c + 1); in_wd = fd[(c < 5) ? c : 4];
      @(negedge clk);
      n_cmp++; if (Write !== 1'b1 || WA !== 5'(10 + c) || WD !== pd)
        begin n_err++; $display("FAIL fill_pipe c=%0d got=%0b/%0d/%h exp=1/%0d/%h", c, Write, WA, WD, 10 + c, pd); end
      n_cmp++; if (count !== 3'((c < 4) ? c : 4) || in_ready !== (c < 4))
        begin n_err++; $display("FAIL fill_count c=%0d got=%0d/%0b exp=%0d/%0b", c, count, in_ready, (c < 4) ? c : 4, c < 4); end
      advance();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (Write !== 1'b1 || WA !== 5'(k + 1) || WD !== fd[k])
        begin n_err++; $display("FAIL fill_order k=%0d got=%0b/%0d/%h exp=1/%0d/%h", k, Write, WA, WD, k + 1, fd[k]); end
      advance();
    end
    @(negedge clk);
    n_cmp++; if (Write !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL fill_drained got=%0b/%0d exp=0/0", Write, count); end
    advance();
  endtask

  task automatic test_fwd_same_addr();
    pipe_write = 1; pipe_wa = 5'd9; pipe_wd = 32'h5;
    rr1 = 5'd7;
    in_valid = 1; in_wa = 5'd7; in_wd = 32'h11;
    advance();
    in_wd = 32'h22;
    @(negedge clk);
    n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h11)
      begin n_err++; $display("FAIL fwd_one got=%0b/%h exp=1/11", fwd1_hit, fwd1_data); end
    advance();
    in_valid = 0;
    @(negedge clk);
    n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22 || count !== 3'd2)
      begin n_err++; $display("FAIL fwd_youngest got=%0b/%h/%0d exp=1/22/2", fwd1_hit, fwd1_data, count); end
    advance();
    pipe_write = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22)
        begin n_err++; $display("FAIL fwd_draining k=%0d got=%0b/%h exp=1/22", k, fwd1_hit, fwd1_data); end
      advance();
    end
    @(negedge clk);
    n_cmp++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0)
      begin n_err++; $display("FAIL fwd_after_drain got=%0b/%h exp=0/0", fwd1_hit, fwd1_data); end
    n_cmp++; if (bank[7] !== 32'h22) begin n_err++; $display("FAIL fwd_bank7 got=%h exp=22", bank[7]); end
    advance();
    idle_inputs();
  endtask

  task automatic test_zero_addr();
    in_valid = 1; in_wa = 5'd0; in_wd = 32'hFFFFFFFF; rr2 = 5'd0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got=%0b exp=1", in_ready); end
    advance();
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (count !== 3'd0 || Write !== 1'b0 || fwd2_hit !== 1'b0)
        begin n_err++; $display("FAIL zero_dropped k=%0d got=%0d/%0b/%0b exp=0/0/0", k, count, Write, fwd2_hit); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    pipe_write = 1; pipe_wa = 5'd9; pipe_wd = 32'h7;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_wa = 5'(20 + c); in_wd = 32'hBEEF0000 + c;
      advance();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (Write !== 1'b1 || WA !== 5'd20 || count !== 3'd3)
      begin n_err++; $display("FAIL midrst_pre got=%0b/%0d/%0d exp=1/20/3", Write, WA, count); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (Write !== 1'b0 || count !== 3'd0)
      begin n_err++; $display("FAIL midrst_async got=%0b/%0d exp=0/0", Write, count); end
    advance();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (Write !== 1'b0 || count !== 3'd0)
        begin n_err++; $display("FAIL midrst_stale k=%0d got=%0b/%0d exp=0/0", k, Write, count); end
      advance();
    end
    n_cmp++; if (bank[21] !== 32'h0 || bank[22] !== 32'h0)
      begin n_err++; $display("FAIL midrst_bank got=%h/%h exp=0/0", bank[21], bank[22]); end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    logic        e_write, e_ready, e_h1, e_h2;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_d1, e_d2;
    for (int c = 0; c < 400; c++) begin
      pipe_write = ($urandom_range(0, 9) < 3);
      pipe_wa = 5'($urandom_range(0, 31)); pipe_wd = $urandom;
      in_valid = ($urandom_range(0, 9) < 6);
      in_wa = 5'($urandom_range(0, 7)); in_wd = $urandom;
      rr1 = 5'($urandom_range(0, 7)); rr2 = 5'($urandom_range(0, 7));
      @(negedge clk);
      e_ready = (q.size() < DEPTH);
      e_write = 0; e_wa = 0; e_wd = 0;
      if (pipe_write) begin e_write = 1; e_wa = pipe_wa; e_wd = pipe_wd; end
      else if (q.size() > 0) begin e_write = 1; e_wa = q[0].a; e_wd = q[0].d; end
      e_h1 = 0; e_d1 = 0; e_h2 = 0; e_d2 = 0;
      foreach (q[i]) begin
        if (rr1 != 0 && q[i].a == rr1) begin e_h1 = 1; e_d1 = q[i].d; end
        if (rr2 != 0 && q[i].a == rr2) begin e_h2 = 1; e_d2 = q[i].d; end
      end
      n_cmp++; if (Write !== e_write || WA !== e_wa || WD !== e_wd)
        begin n_err++; $display("FAIL rand_port c=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", c, Write, WA, WD, e_write, e_wa, e_wd); end
      n_cmp++; if (in_ready !== e_ready || count !== 3'(q.size()))
        begin n_err++; $display("FAIL rand_occ c=%0d got=%0b/%0d exp=%0b/%0d", c, in_ready, count, e_ready, q.size()); end
      n_cmp++; if (fwd1_hit !== e_h1 || fwd1_data !== e_d1 || fwd2_hit !== e_h2 || fwd2_data !== e_d2)
        begin n_err++; $display("FAIL rand_fwd c=%0d got=%0b/%h %0b/%h exp=%0b/%h %0b/%h", c, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, e_h1, e_d1, e_h2, e_d2); end
      @(posedge clk);
      if (!pipe_write && q.size() > 0) void'(q.pop_front());
      if (in_valid && e_ready && in_wa != 0) q.push_back('{a: in_wa, d: in_wd});
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_full();
    test_fwd_same_addr();
    test_zero_addr();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
